// File: rtl/aes_pkg.sv
// aes_pkg: shared constants for the inverse SubBytes datapath.
// Holds the AES inverse S-box table, the sequencer state encoding and the
// mask of legal lane counts.
package aes_pkg;

  // Sequencer states; DRAIN is only reachable when the lookup pipeline
  // register is built in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } inv_sub_state_e;

  // Bit k set means LANES = k is legal (1, 2, 4, 8, 16).
  localparam int unsigned LANES_LEGAL_MASK = 32'h0001_0116;

  // AES inverse S-box, indexed by the ciphertext-side byte.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox_lut.sv
// inv_sbox_lut: one combinational 8-bit inverse S-box lookup.
module inv_sbox_lut
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq: sequential AES InvSubBytes over a 128-bit state using
// LANES shared inverse S-box lookups per cycle (16/LANES busy cycles).
// Optional macro INV_SUB_OUT_REG_EN inserts a register after the lookups;
// the result write then lags one cycle and a DRAIN state is added.
module inv_subbytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);

  localparam int N  = 16 / LANES;                 // busy cycles per word
  localparam int CW = $clog2(N) + 1;              // counter width
  localparam int IW = (N > 1) ? $clog2(N) : 1;    // group index width
  localparam int WW = 8 * LANES;                  // bits looked up per cycle

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_BUSY  = ST_BUSY;
  localparam logic [1:0] S_DONE  = ST_DONE;
`ifdef INV_SUB_OUT_REG_EN
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
`endif

  if (((LANES_LEGAL_MASK >> LANES) & 32'd1) == 32'd0) begin : g_bad_lanes
    $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]           fsm_q, fsm_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N-1:0][WW-1:0] data_q;     // captured input, viewed as N lane groups
  logic [N-1:0][WW-1:0] res_q;      // result register, same grouping
  logic [IW-1:0]        cnt_idx;
  logic [WW-1:0]        cur_word;
  logic [WW-1:0]        lut_word;
  logic                 accept;
  logic                 wr_en;
  logic [IW-1:0]        wr_idx;
  logic [WW-1:0]        wr_word;

  assign in_ready  = (fsm_q == S_IDLE);
  assign busy      = !in_ready;
  assign out_valid = (fsm_q == S_DONE);
  assign out       = res_q;
  assign accept    = in_ready && in_valid && !flush;
  assign cnt_idx   = cnt_q[IW-1:0];
  assign cur_word  = data_q[cnt_idx];

  // Next-state and counter logic; flush overrides every transition.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          fsm_d = S_BUSY;
          cnt_d = '0;
        end
      end
      S_BUSY: begin
        if (cnt_q == CW'(N - 1)) begin
`ifdef INV_SUB_OUT_REG_EN
          fsm_d = S_DRAIN;
`else
          fsm_d = S_DONE;
`endif
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef INV_SUB_OUT_REG_EN
      S_DRAIN: fsm_d = S_DONE;
`endif
      S_DONE: begin
        if (out_ready) fsm_d = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
    if (flush) begin
      fsm_d = S_IDLE;
      cnt_d = '0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      fsm_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
    end
  end

  // Capture the offered word on accept.
  always_ff @(posedge clk) begin
    // NOTE: data_q is deliberately not reset; it is always loaded on accept
    // before any lookup reads it, so a reset would only cost routing.
    if (accept) data_q <= state;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lut
    inv_sbox_lut u_lut (
      .din  (cur_word[8*l +: 8]),
      .dout (lut_word[8*l +: 8])
    );
  end

`ifdef INV_SUB_OUT_REG_EN
  logic          pipe_vld_q;
  logic [IW-1:0] pipe_idx_q;
  logic [WW-1:0] pipe_word_q;

  // Valid flag of the lookup pipeline; cleared by reset and flush.
  always_ff @(posedge clk) begin
    if (rst || flush) pipe_vld_q <= 1'b0;
    else              pipe_vld_q <= (fsm_q == S_BUSY);
  end

  // Lookup results and their group index, one cycle behind the lookup.
  always_ff @(posedge clk) begin
    pipe_idx_q  <= cnt_idx;
    pipe_word_q <= lut_word;
  end

  assign wr_en   = pipe_vld_q;
  assign wr_idx  = pipe_idx_q;
  assign wr_word = pipe_word_q;
`else
  assign wr_en   = (fsm_q == S_BUSY);
  assign wr_idx  = cnt_idx;
  assign wr_word = lut_word;
`endif

  // Result register: one lane group written per cycle, the rest hold.
  always_ff @(posedge clk) begin
    if (rst)                  res_q <= '0;
    else if (wr_en && !flush) res_q[wr_idx] <= wr_word;
  end

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// tb_inv_subbytes_seq: drives five instances (LANES = 1, 2, 4, 8, 16) with a
// shared stimulus. Each instance has a cycle-level reference model built on
// an inverse S-box derived from GF(2^8) arithmetic, compared every cycle,
// plus directed checks with hand-computed values on the LANES=1 instance.
module tb_inv_subbytes_seq;

  localparam int NCFG = 5;
`ifdef INV_SUB_OUT_REG_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] state = '0;

  logic [NCFG-1:0] in_ready_v;
  logic [NCFG-1:0] busy_v;
  logic [NCFG-1:0] out_valid_v;
  logic [127:0]    out_v [NCFG];

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed    = 1'b0;
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 128'(act), 128'(exp));
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Inverse S-box from first principles: inverse affine map, then GF inverse.
  task automatic build_table();
    logic [7:0] x, b, inv;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      b   = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gf_mul(b, 8'(y)) == 8'h01) inv = 8'(y);
      inv_tab[i] = inv;
    end
  endtask

  function automatic logic [127:0] inv_sub_model(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
    return r;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int L   = 1 << g;
    localparam int LAT = 16 / L + EXTRA;

    inv_subbytes_seq #(.LANES(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .state     (state),
      .flush     (flush),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .out       (out_v[g]),
      .busy      (busy_v[g])
    );

    // Model: idle / working (count down LAT edges) / done holding result.
    bit           m_idle = 1'b1;
    bit           m_done = 1'b0;
    bit           m_zero = 1'b1;
    int           m_left = 0;
    logic [127:0] m_res  = '0;

    always @(posedge clk) begin
      if (rst) begin
        m_idle <= 1'b1;
        m_done <= 1'b0;
        m_zero <= 1'b1;
        m_left <= 0;
      end else if (flush) begin
        m_idle <= 1'b1;
        m_done <= 1'b0;
        m_left <= 0;
      end else if (m_idle) begin
        if (in_valid) begin
          m_idle <= 1'b0;
          m_left <= LAT;
          m_res  <= inv_sub_model(state);
          m_zero <= 1'b0;
        end
      end else if (!m_done) begin
        if (m_left == 1) m_done <= 1'b1;
        m_left <= m_left - 1;
      end else if (out_ready) begin
        m_done <= 1'b0;
        m_idle <= 1'b1;
      end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
      if (armed) begin
        check_bit($sformatf("L%0d in_ready", L), in_ready_v[g], m_idle);
        check_bit($sformatf("L%0d busy", L), busy_v[g], !m_idle);
        check_bit($sformatf("L%0d out_valid", L), out_valid_v[g], m_done);
        if (m_done) check($sformatf("L%0d out", L), out_v[g], m_res);
        if (m_zero) check($sformatf("L%0d out_after_reset", L), out_v[g], 128'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] s);
    int k;
    k = 0;
    while (!in_ready_v[0] && k < 200) begin
      tick();
      k++;
    end
    check_bit("send_ready", in_ready_v[0], 1'b1);
    state    = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid_v[0] && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int           lat;
    logic [127:0] r;

    build_table();
    check("model_63", 128'(inv_tab[8'h63]), 128'h00);
    check("model_00", 128'(inv_tab[8'h00]), 128'h52);
    check("model_01", 128'(inv_tab[8'h01]), 128'h09);
    check("model_7c", 128'(inv_tab[8'h7c]), 128'h01);
    check("model_ff", 128'(inv_tab[8'hff]), 128'h7d);

    // Reset state.
    rst = 1'b1;
    tick();
    armed = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      check_bit("reset_in_ready", in_ready_v[i], 1'b1);
      check_bit("reset_busy", busy_v[i], 1'b0);
      check_bit("reset_out_valid", out_valid_v[i], 1'b0);
      check("reset_out", out_v[i], 128'h0);
    end

    // All 8'h63 -> zero, with latency and a 5-cycle consumer stall.
    out_ready = 1'b0;
    send({16{8'h63}});
    wait_valid(lat);
    check("lat_63", 128'(lat), 128'(16 + EXTRA));
    check("out_63", out_v[0], 128'h0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      state    = rnd128();
      tick();
      check_bit("hold_out_valid", out_valid_v[0], 1'b1);
      check("hold_out", out_v[0], 128'h0);
      check_bit("hold_in_ready", in_ready_v[0], 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_bit("release_idle", in_ready_v[0], 1'b1);

    // All zero -> sixteen 8'h52.
    send(128'h0);
    wait_valid(lat);
    check("out_zero_state", out_v[0], {16{8'h52}});

    // Mixed bytes 00, 01, 7c, ff in bytes 0..3, 8'h63 elsewhere.
    send(128'h63636363_63636363_63636363_ff7c0100);
    wait_valid(lat);
    check("out_mixed", out_v[0], 128'h00000000_00000000_00000000_7d010952);

    // Flush at BUSY cnt=7, then a fresh word must complete correctly.
    tick();
    send(rnd128());
    repeat (7) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_bit("flush_in_ready", in_ready_v[0], 1'b1);
    check_bit("flush_busy", busy_v[0], 1'b0);
    repeat (20) tick();
    check_bit("flush_no_valid", out_valid_v[0], 1'b0);
    r = rnd128();
    send(r);
    wait_valid(lat);
    check("lat_after_flush", 128'(lat), 128'(16 + EXTRA));
    check("out_after_flush", out_v[0], inv_sub_model(r));

    // Reset at BUSY cnt=3.
    tick();
    send(rnd128());
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out", out_v[0], 128'h0);
    check_bit("rst_mid_busy", busy_v[0], 1'b0);
    check_bit("rst_mid_in_ready", in_ready_v[0], 1'b1);

    // Random words with occasional consumer stalls.
    for (int n = 0; n < 6; n++) begin
      r = rnd128();
      out_ready = 1'b0;
      send(r);
      wait_valid(lat);
      check("rand_lat", 128'(lat), 128'(16 + EXTRA));
      check("rand_out", out_v[0], inv_sub_model(r));
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
    end

    // Continuous offers: every instance back-to-back with its own pace.
    in_valid = 1'b1;
    for (int n = 0; n < 120; n++) begin
      state = rnd128();
      tick();
    end
    in_valid = 1'b0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_subbytes_seq.md
INV_SUBBYTES_SEQ -- requirements
Module: inv_subbytes_seq

Interface
REQ-001 Parameter LANES, default 1: number of shared inverse S-box lookups per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  state word offered.
REQ-005 in_ready  output  1  block can accept a state word.
REQ-006 state  input  128  ciphertext-side state; byte i = state[8i+:8].
REQ-007 flush  input  1  synchronous abort of the current operation.
REQ-008 out_valid  output  1  result held on out.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out  output  128  InvSubBytes(state); byte i = InvS(state byte i).
REQ-011 busy  output  1  high in every state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, DRAIN (present only with INV_SUB_OUT_REG_EN) and DONE.
REQ-013 in_ready SHALL equal (state==IDLE); an accept occurs on a cycle with in_valid && in_ready, which captures state into an internal 128-bit register and moves the FSM to BUSY.
REQ-014 BUSY SHALL last exactly N = 16/LANES cycles, with a counter cnt running 0..N-1.
REQ-015 On BUSY cycle cnt, the block SHALL look up bytes cnt*LANES .. cnt*LANES+LANES-1, in ascending byte order.
REQ-016 Each looked-up byte SHALL be written to the matching byte of the result register; bytes not yet processed SHALL hold their previous value.
REQ-017 When cnt==N-1, the FSM SHALL go to DRAIN if the macro is defined, otherwise to DONE.
REQ-018 DRAIN SHALL last one cycle and then go to DONE.
REQ-019 out_valid SHALL be high only in DONE; out SHALL stay stable while out_valid && !out_ready.
REQ-020 In DONE with out_ready=1, the FSM SHALL return to IDLE on the next edge; a new accept is possible no earlier than the following cycle (no back-to-back overlap).
REQ-021 Latency from the accept edge to out_valid high SHALL be N cycles without the macro and N+1 cycles with it; for LANES=1 this is 16 or 17.
REQ-022 flush=1 in any state SHALL force IDLE and cnt=0 on the next edge and discard any result; flush has priority over accept and over out_ready.
REQ-023 in_valid while not in IDLE SHALL be ignored and the input SHALL not be captured.
REQ-024 cnt SHALL be $clog2(N)+1 bits wide and wrap to 0 on leaving BUSY; for LANES=16 (N=1) the single BUSY cycle SHALL process all 16 bytes.

Reset
REQ-025 rst=1 SHALL set FSM=IDLE, cnt=0, out=128'h0, out_valid=0, busy=0 and in_ready=1 on the next edge.
REQ-026 rst SHALL override flush and all handshakes; reset mid-operation SHALL discard the operation with no partial output.

Configuration
REQ-027 Macro INV_SUB_OUT_REG_EN defined: a pipeline register SHALL follow the S-box lookups, the result-register write SHALL lag by one cycle, and the DRAIN state SHALL exist.
REQ-028 INV_SUB_OUT_REG_EN undefined: lookup results SHALL be written combinationally into the result register in the same BUSY cycle, and there SHALL be no DRAIN state.

Structure
REQ-029 Package aes_pkg SHALL hold the 256-entry inverse S-box constant table, the FSM state enum and the LANES legality check constant.
REQ-030 Sub-module inv_sbox_lut SHALL implement one 8-bit to 8-bit combinational lookup and SHALL be instantiated LANES times.

Verification
REQ-031 LANES=1, state=16 bytes of 8'h63 -> out=128'h0, with out_valid rising 16 cycles after accept (17 with the macro).
REQ-032 state=128'h0 -> out = sixteen bytes of 8'h52; state bytes 0..3 = 8'h00, 8'h01, 8'h7c, 8'hff -> out bytes 0..3 = 8'h52, 8'h09, 8'h01, 8'h7d.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and out is unchanged; in_valid pulses during this window are ignored.
REQ-034 Assert flush at BUSY cnt=7 -> IDLE next cycle, out_valid never rises, and the next accepted word produces a correct result.
REQ-035 Assert rst at BUSY cnt=3 -> next cycle out=0, busy=0, in_ready=1.
REQ-036 Sweep LANES over 1, 2, 4, 8, 16 with random states checked against a model -> outputs match and latency = 16/LANES (+1 with the macro).
